// File: rtl/prng_bit_packer.sv
// prng_bit_packer
// Takes one PRNG word per bits_ready pulse, picks the raw or debiased bits and
// serialises them MSB-first into bytes. Bytes are queued in a small FIFO that
// drives a valid/ready output port.
// Optional statistics counters are built when PRNG_PACK_STATS_EN is defined.
module prng_bit_packer #(
  parameter int MIN_DEB    = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_W     = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            bits_ready,
  input  logic [87:0]                     raw_bits,
  input  logic [43:0]                     debiased_bits,
  input  logic [6:0]                      debiased_count,
  input  logic                            flush,
  output logic [7:0]                      m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [DROP_W-1:0]               drop_count
`ifdef PRNG_PACK_STATS_EN
  ,
  output logic [31:0]                     word_count,
  output logic [31:0]                     raw_sel_count,
  output logic [31:0]                     ones_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [87:0]        hold;
  logic [6:0]         len;
  logic [6:0]         idx;
  logic [7:0]         acc;
  logic [2:0]         bitcnt;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   count;

  logic               sel_raw;
  logic [6:0]         deb_len;
  logic [6:0]         cap_len;
  logic               capture;
  logic               drop;
  logic               cur_bit;
  logic               full;
  logic               empty;
  logic               shift_go;
  logic               last_bit;
  logic               flush_go;
  logic               push;
  logic               pop;
  logic [7:0]         acc_set;
  logic [7:0]         push_data;

  // Word source selection and capture/drop decode.
  always_comb begin
    sel_raw = ({25'd0, debiased_count} < 32'(MIN_DEB));
    if (debiased_count > 7'd44) begin
      deb_len = 7'd44;
    end else begin
      deb_len = debiased_count;
    end
    if (sel_raw) begin
      cap_len = 7'd88;
    end else begin
      cap_len = deb_len;
    end
    // A zero-length word never leaves IDLE.
    capture = bits_ready && enable && (state == IDLE) && (cap_len != 7'd0);
    drop    = bits_ready && enable && (state == SHIFT);
  end

  // Bit serialiser and FIFO handshake decode.
  always_comb begin
    cur_bit  = hold[idx];
    full     = (count == LVL_W'(FIFO_DEPTH));
    empty    = (count == LVL_W'(0));
    // Completing a byte needs FIFO room; otherwise the shifter stalls.
    shift_go = (state == SHIFT) && !((bitcnt == 3'd7) && full);
    last_bit = (idx == (len - 7'd1));
    if (cur_bit) begin
      acc_set = acc | (8'h80 >> bitcnt);
    end else begin
      acc_set = acc;
    end
    flush_go = flush && (state == IDLE) && !capture && (bitcnt != 3'd0) && !full;
    if (flush_go) begin
      push_data = acc;
    end else begin
      push_data = acc_set;
    end
    push = (shift_go && (bitcnt == 3'd7)) || flush_go;
    pop  = !empty && m_ready;
  end

  // Next-state logic for the capture/shift FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (capture) begin
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (shift_go && last_bit) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = SHIFT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Word hold register, bit index and partial-byte accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold   <= 88'd0;
      len    <= 7'd0;
      idx    <= 7'd0;
      acc    <= 8'd0;
      bitcnt <= 3'd0;
    end else if (capture) begin
      if (sel_raw) begin
        hold <= raw_bits;
      end else begin
        hold <= {44'd0, debiased_bits};
      end
      len <= cap_len;
      idx <= 7'd0;
    end else if (shift_go) begin
      idx    <= idx + 7'd1;
      bitcnt <= bitcnt + 3'd1;
      if (bitcnt == 3'd7) begin
        acc <= 8'd0;
      end else begin
        acc <= acc_set;
      end
    end else if (flush_go) begin
      acc    <= 8'd0;
      bitcnt <= 3'd0;
    end
  end

  // Saturating count of words lost to overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != {DROP_W{1'b1}})) begin
      drop_count <= drop_count + DROP_W'(1);
    end
  end

  // FIFO storage; contents are only observable through a valid pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and fill level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign m_valid    = !empty;
  assign m_data     = empty ? 8'h00 : mem[rd_ptr];
  assign busy       = (state == SHIFT);
  assign fifo_level = count;

`ifdef PRNG_PACK_STATS_EN
  // Statistics on accepted words and emitted one-bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count    <= 32'd0;
      raw_sel_count <= 32'd0;
      ones_count    <= 32'd0;
    end else begin
      if (capture) begin
        word_count <= word_count + 32'd1;
      end
      if (capture && sel_raw) begin
        raw_sel_count <= raw_sel_count + 32'd1;
      end
      if (shift_go && cur_bit) begin
        ones_count <= ones_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prng_bit_packer.sv
// Scoreboard bench for prng_bit_packer: expected bytes are queued when a word
// is issued, and a monitor pops/compares on every m_valid&&m_ready handshake.
module tb_prng_bit_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        bits_ready;
  logic        bits_ready2;
  logic [87:0] raw_bits;
  logic [43:0] debiased_bits;
  logic [6:0]  debiased_count;
  logic        flush;
  logic        m_ready;

  logic [7:0]  m_data;
  logic        m_valid;
  logic        busy;
  logic [4:0]  fifo_level;
  logic [15:0] drop_count;

  logic [7:0]  m_data2;
  logic        m_valid2;
  logic        busy2;
  logic [4:0]  fifo_level2;
  logic [1:0]  drop_count2;

`ifdef PRNG_PACK_STATS_EN
  logic [31:0] word_count, raw_sel_count, ones_count;
  logic [31:0] word_count2, raw_sel_count2, ones_count2;
`endif

  int          passed = 0;
  int          total  = 0;
  logic [7:0]  sb [$];
  logic [7:0]  exp_b;

  prng_bit_packer dut (
    .clk(clk), .reset(reset), .enable(enable), .bits_ready(bits_ready),
    .raw_bits(raw_bits), .debiased_bits(debiased_bits),
    .debiased_count(debiased_count), .flush(flush),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .fifo_level(fifo_level), .drop_count(drop_count)
`ifdef PRNG_PACK_STATS_EN
    , .word_count(word_count), .raw_sel_count(raw_sel_count), .ones_count(ones_count)
`endif
  );

  prng_bit_packer #(.DROP_W(2)) dut_sat (
    .clk(clk), .reset(reset), .enable(1'b1), .bits_ready(bits_ready2),
    .raw_bits(raw_bits), .debiased_bits(debiased_bits),
    .debiased_count(debiased_count), .flush(1'b0),
    .m_data(m_data2), .m_valid(m_valid2), .m_ready(1'b1),
    .busy(busy2), .fifo_level(fifo_level2), .drop_count(drop_count2)
`ifdef PRNG_PACK_STATS_EN
    , .word_count(word_count2), .raw_sel_count(raw_sel_count2), .ones_count(ones_count2)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [87:0] raw, input logic [43:0] deb, input logic [6:0] cnt);
    raw_bits       = raw;
    debiased_bits  = deb;
    debiased_count = cnt;
    bits_ready     = 1'b1;
    tick(1);
    bits_ready     = 1'b0;
  endtask

  task automatic expect_raw(input logic [87:0] raw);
    for (int k = 0; k < 11; k++) sb.push_back(rev8(raw[8*k +: 8]));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      tick(1);
      n++;
    end
    chk(name, sb.size(), 32'd0);
    tick(2);
    chk({name, "_level"}, {27'd0, fifo_level}, 32'd0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  // Monitor: compare every accepted output byte against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL extra_byte: got %02h expected none", m_data);
      end else begin
        exp_b = sb.pop_front();
        if (m_data === exp_b) passed++;
        else $display("FAIL byte: got %02h expected %02h", m_data, exp_b);
      end
    end
  end

  initial begin
    logic [87:0] wa, wb, wc, we;
    reset = 1'b1; enable = 1'b1; bits_ready = 1'b0; bits_ready2 = 1'b0;
    raw_bits = 88'd0; debiased_bits = 44'd0; debiased_count = 7'd0;
    flush = 1'b0; m_ready = 1'b0;
    tick(3);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_level", {27'd0, fifo_level}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_drop", {16'd0, drop_count}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    reset = 1'b0;
    tick(2);

    // T1: raw source, first emitted bit lands in the byte MSB.
    m_ready = 1'b1;
    sb.push_back(8'h80);
    for (int k = 0; k < 10; k++) sb.push_back(8'h00);
    send(88'h1, 44'd0, 7'd10);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_drain("t1_drain");
    chk("t1_drop", {16'd0, drop_count}, 32'd0);

    // T2: two 36-bit debiased words carry 4 bits across the word boundary.
    for (int k = 0; k < 9; k++) sb.push_back(8'hFF);
    send(88'd0, 44'hFFF_FFFF_FFFF, 7'd36);
    wait_idle("t2_idle1");
    send(88'd0, 44'hFFF_FFFF_FFFF, 7'd36);
    wait_drain("t2_drain");
    pulse_flush();
    tick(3);
    chk("t2_no_partial", {27'd0, fifo_level}, 32'd0);
    chk("t2_no_valid", {31'd0, m_valid}, 32'd0);

    // T3: flush pads the 4 leftover bits with zeros; a second flush is a no-op.
    for (int k = 0; k < 4; k++) sb.push_back(8'hFF);
    send(88'd0, 44'hFFF_FFFF_FFFF, 7'd36);
    wait_drain("t3_drain");
    sb.push_back(8'hF0);
    pulse_flush();
    wait_drain("t3_flush");
    pulse_flush();
    tick(3);
    chk("t3_flush2_level", {27'd0, fifo_level}, 32'd0);
    chk("t3_flush2_valid", {31'd0, m_valid}, 32'd0);

    // Disabled input: bits_ready is ignored.
    enable = 1'b0;
    send(88'hFF_FFFF_FFFF_FFFF_FFFF_FFFF, 44'd0, 7'd0);
    tick(3);
    chk("dis_busy", {31'd0, busy}, 32'd0);
    chk("dis_level", {27'd0, fifo_level}, 32'd0);
    enable = 1'b1;

    // T4: backpressure fills the FIFO and stalls the shifter.
    m_ready = 1'b0;
    wa = 88'h0123_4567_89AB_CDEF_FEDC_BA;
    wb = 88'hA5A5_3C3C_0F0F_F0F0_5A5A_C3;
    expect_raw(wa);
    send(wa, 44'd0, 7'd0);
    wait_idle("t4_idle_a");
    chk("t4_level11", {27'd0, fifo_level}, 32'd11);
    expect_raw(wb);
    send(wb, 44'd0, 7'd0);
    tick(100);
    chk("t4_stall_busy", {31'd0, busy}, 32'd1);
    chk("t4_level16", {27'd0, fifo_level}, 32'd16);
    chk("t4_head", {24'd0, m_data}, {24'd0, rev8(wa[7:0])});
    tick(5);
    chk("t4_stable", {24'd0, m_data}, {24'd0, rev8(wa[7:0])});
    chk("t4_still_busy", {31'd0, busy}, 32'd1);
    m_ready = 1'b1;
    wait_drain("t4_drain");

    // T5: second word 20 clk after the first is dropped.
    wc = 88'h1122_3344_5566_7788_99AA_BB;
    expect_raw(wc);
    send(wc, 44'd0, 7'd0);
    tick(19);
    send(88'hFF_FFFF_FFFF_FFFF_FFFF_FFFF, 44'd0, 7'd0);
    wait_drain("t5_drain");
    chk("t5_drop", {16'd0, drop_count}, 32'd1);

    // T5 saturation on a 2-bit drop counter.
    raw_bits = 88'd0; debiased_count = 7'd0;
    bits_ready2 = 1'b1; tick(1); bits_ready2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(4);
      bits_ready2 = 1'b1; tick(1); bits_ready2 = 1'b0;
      if (k == 1) chk("t5_sat_two", {30'd0, drop_count2}, 32'd2);
    end
    chk("t5_sat_five", {30'd0, drop_count2}, 32'd3);

    // T6: reset in the middle of a word discards everything.
    m_ready = 1'b0;
    send(88'hFF_FFFF_FFFF_FFFF_FFFF_FFFF, 44'd0, 7'd0);
    tick(40);
    reset = 1'b1;
    tick(1);
    chk("t6_m_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_level", {27'd0, fifo_level}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_drop", {16'd0, drop_count}, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    m_ready = 1'b1;
    we = 88'hC0FF_EE00_1234_5678_9ABC_DE;
    expect_raw(we);
    send(we, 44'd0, 7'd0);
    wait_drain("t6_fresh");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
